// File: rtl/spiker_frame_ctrl_pkg.sv
// Shared types and helpers for the spike frame controller.
package spiker_ctrl_pkg;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RUN     = 2'd2,
    ST_CAPTURE = 2'd3
  } ctrl_state_e;

  // Fixed pipeline depth of spiker_reader.
  localparam int DEFAULT_CORE_LATENCY = 4;

  // Number of WIDTH-bit registers needed to hold n_spikes bits.
  function automatic int n_reg(input int n_spikes, input int width);
    return (n_spikes + width - 1) / width;
  endfunction

endpackage

// File: rtl/spiker_frame_ctrl_if.sv
// Register-file / core-facing bundle of the spike frame controller.
// Signal suffixes are from the controller's point of view.
interface spiker_frame_ctrl_if #(
  parameter int WIDTH    = 32,
  parameter int N_SPIKES = 784,
  parameter int CNT_W    = 16
) ();
  localparam int DATA_WIDTH = spiker_ctrl_pkg::n_reg(N_SPIKES, WIDTH) * WIDTH;

  logic                  start_i;
  logic                  clear_i;
  logic [DATA_WIDTH-1:0] spikes_i;
  logic [N_SPIKES-1:0]   core_data_o;
  logic [N_SPIKES-1:0]   core_data_i;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic                  irq_o;
  logic [CNT_W-1:0]      frame_cnt_o;

  // Controller side.
  modport slave (
    input  start_i, clear_i, spikes_i, core_data_i,
    output core_data_o, result_o, busy_o, done_o, err_o, irq_o, frame_cnt_o
  );

  // Register file / core side.
  modport master (
    output start_i, clear_i, spikes_i, core_data_i,
    input  core_data_o, result_o, busy_o, done_o, err_o, irq_o, frame_cnt_o
  );

endinterface

// File: rtl/spiker_frame_ctrl.sv
// Sequences one spike frame through spiker_reader per start command:
// snapshot spikes, hold them for CORE_LATENCY cycles, capture the core
// output, then flag done/irq and bump the frame counter.
// CORE_LATENCY must be at least 1.
module spiker_frame_ctrl
  import spiker_ctrl_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int N_SPIKES     = 784,
  parameter int CORE_LATENCY = DEFAULT_CORE_LATENCY,
  parameter int CNT_W        = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  spiker_frame_ctrl_if.slave  bus
);

  localparam int N_REG      = n_reg(N_SPIKES, WIDTH);
  localparam int DATA_WIDTH = N_REG * WIDTH;
  localparam int LAT_W      = $clog2(CORE_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CORE_LATENCY - 1);

  ctrl_state_e           state_q, state_d;
  logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic [N_SPIKES-1:0]   frame_q;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0]      frame_cnt_q;
  logic                  busy_q, done_q, err_q, irq_q;
  logic                  accept, reject, load_en, capture_en;

  // Padding bits of the top spike register never reach the core.
  logic unused_spikes;
  assign unused_spikes = ^bus.spikes_i;

  // State register.
  // NOTE: clocked state uses <= so every flop samples pre-edge values; = here would create order-dependent races.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state and latency counter update.
  // NOTE: every output of an always_comb gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      ST_IDLE:    if (bus.start_i) state_d = ST_LOAD;
      ST_LOAD: begin
        state_d   = ST_RUN;
        lat_cnt_d = '0;
      end
      ST_RUN: begin
        lat_cnt_d = lat_cnt_q + LAT_W'(1);
        if (lat_cnt_q == LAT_LAST) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    accept     = 1'b0;
    load_en    = 1'b0;
    capture_en = 1'b0;
    case (state_q)
      ST_IDLE:    accept     = bus.start_i;
      ST_LOAD:    load_en    = 1'b1;
      ST_CAPTURE: capture_en = 1'b1;
      default:    ;
    endcase
    reject = bus.start_i && (state_q != ST_IDLE);
  end

  // Zero-extend the core output to the full register span.
  always_comb begin
    result_d                 = '0;
    result_d[N_SPIKES-1:0]   = bus.core_data_i;
  end

  // Frame, result, counter and sticky status registers.
  // NOTE: frame and result are wide but are plain flops that software may read right after reset, so they are reset like the rest.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lat_cnt_q   <= '0;
      frame_q     <= '0;
      result_q    <= '0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      lat_cnt_q <= lat_cnt_d;
      if (load_en) frame_q <= bus.spikes_i[N_SPIKES-1:0];
      if (capture_en) begin
        result_q    <= result_d;
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
      busy_q <= (state_d != ST_IDLE);
      irq_q  <= capture_en;
      // A capture beats a concurrent clear; an accepted start clears done.
      if (capture_en)                  done_q <= 1'b1;
      else if (accept || bus.clear_i)  done_q <= 1'b0;
      // A rejected start beats a concurrent clear.
      if (reject)           err_q <= 1'b1;
      else if (bus.clear_i) err_q <= 1'b0;
    end
  end

  assign bus.core_data_o = frame_q;
  assign bus.result_o    = result_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.irq_o       = irq_q;
  assign bus.frame_cnt_o = frame_cnt_q;

endmodule
